// File: rtl/painter_pkg.sv
// Shared definitions for the painter draw path: opcodes, word fields, screen size, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package painter_pkg;

  // Default screen geometry
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  // Command word layout: opcode in the top nibble, payload in the low bits
  localparam int WORD_W  = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int COLOR_W = 3;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  localparam logic [3:0] OP_RECT  = 4'h1;
  localparam logic [3:0] OP_CLEAR = 4'h2;

  // Word index within a command
  localparam logic [2:0] IDX_HDR = 3'd0;
  localparam logic [2:0] IDX_X0  = 3'd1;
  localparam logic [2:0] IDX_Y0  = 3'd2;
  localparam logic [2:0] IDX_X1  = 3'd3;
  localparam logic [2:0] IDX_Y1  = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Request as latched at acceptance, coordinates already ordered and clipped
  typedef struct packed {
    logic               op;     // 0 = RECT, 1 = CLEAR
    logic [COLOR_W-1:0] color;
    logic [X_W-1:0]     x0;
    logic [X_W-1:0]     x1;
    logic [Y_W-1:0]     y0;
    logic [Y_W-1:0]     y1;
  } cmd_t;

  // Header word: opcode nibble, zero gap, colour in the low bits
  function automatic logic [WORD_W-1:0] hdr_word(input logic op, input logic [COLOR_W-1:0] color);
    logic [3:0] opc;
    opc = op ? OP_CLEAR : OP_RECT;
    return {opc, 9'b0, color};
  endfunction

endpackage

// File: rtl/draw_coord_clip.sv
// Orders two corner coordinates of one axis and clamps both to the last visible pixel.
// Latency: purely combinational.
// Backpressure: none.
module draw_coord_clip
  import painter_pkg::*;
#(
  parameter int W     = X_W,
  parameter int LIMIT = H_RES_DEF - 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  localparam logic [W-1:0] LIM = LIMIT[W-1:0];

  logic [W-1:0] mn;
  logic [W-1:0] mx;

  // Swap into ascending order, then clamp each end independently
  always_comb begin
    mn = (a < b) ? a : b;
    mx = (a < b) ? b : a;
    lo = (mn > LIM) ? LIM : mn;
    hi = (mx > LIM) ? LIM : mx;
  end

endmodule

// File: rtl/draw_cmd_issuer.sv
// Turns RECT/CLEAR requests into 16-bit command words for the draw unit FIFO.
// Latency: first word one cycle after acceptance; RECT 5 words, CLEAR 1 word, back to back.
// Backpressure: full holds the current word (we and data unchanged); one request in flight.
module draw_cmd_issuer
  import painter_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [2:0]  req_color,
  input  logic [9:0]  req_x0,
  input  logic [9:0]  req_x1,
  input  logic [8:0]  req_y0,
  input  logic [8:0]  req_y1,
  output logic        we,
  output logic [15:0] data,
  input  logic        full,
  output logic        busy
);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  cmd_t       cmd_q, cmd_d;

  logic [X_W-1:0] x_lo, x_hi;
  logic [Y_W-1:0] y_lo, y_hi;
  logic           last_word;

  draw_coord_clip #(.W(X_W), .LIMIT(H_RES - 1)) u_clip_x (
    .a  (req_x0),
    .b  (req_x1),
    .lo (x_lo),
    .hi (x_hi)
  );

  draw_coord_clip #(.W(Y_W), .LIMIT(V_RES - 1)) u_clip_y (
    .a  (req_y0),
    .b  (req_y1),
    .lo (y_lo),
    .hi (y_hi)
  );

  // CLEAR is header-only; RECT ends on the Y1 word
  assign last_word = cmd_q.op ? (idx_q == IDX_HDR) : (idx_q == IDX_Y1);

  // State register; reset abandons any partially issued command
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_HDR;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next state: latch the normalised request in IDLE, step words only when the FIFO takes them
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cmd_d.op    = req_op;
          cmd_d.color = req_color;
          cmd_d.x0    = x_lo;
          cmd_d.x1    = x_hi;
          cmd_d.y0    = y_lo;
          cmd_d.y1    = y_hi;
          idx_d       = IDX_HDR;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!full) begin
          if (last_word) begin
            idx_d   = IDX_HDR;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from state; reset forces them quiet in the same cycle it is raised
  always_comb begin
    req_ready = 1'b0;
    we        = 1'b0;
    busy      = 1'b0;
    data      = '0;
    if (!reset) begin
      req_ready = (state_q == ST_IDLE);
      if (state_q == ST_EMIT) begin
        we   = 1'b1;
        busy = 1'b1;
        case (idx_q)
          IDX_HDR: data = hdr_word(cmd_q.op, cmd_q.color);
          IDX_X0:  data = {6'b0, cmd_q.x0};
          IDX_Y0:  data = {7'b0, cmd_q.y0};
          IDX_X1:  data = {6'b0, cmd_q.x1};
          IDX_Y1:  data = {7'b0, cmd_q.y1};
          default: data = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_draw_cmd_issuer.sv
// Self-checking bench for draw_cmd_issuer: scoreboard of expected command words.
// Latency: checks first word one cycle after acceptance and back-to-back emission.
// Backpressure: drives full both in fixed windows and randomly.
module tb_draw_cmd_issuer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [2:0]  req_color;
  logic [9:0]  req_x0, req_x1;
  logic [8:0]  req_y0, req_y1;
  logic        we;
  logic [15:0] data;
  logic        full;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] sb[$];

  draw_cmd_issuer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_color (req_color),
    .req_x0    (req_x0),
    .req_x1    (req_x1),
    .req_y0    (req_y0),
    .req_y1    (req_y1),
    .we        (we),
    .data      (data),
    .full      (full),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference clip: order the pair then saturate at the screen edge
  function automatic logic [9:0] ref_lo(input logic [9:0] a, input logic [9:0] b, input int lim);
    int v;
    v = (a <= b) ? int'(a) : int'(b);
    if (v > lim) v = lim;
    return v[9:0];
  endfunction

  function automatic logic [9:0] ref_hi(input logic [9:0] a, input logic [9:0] b, input int lim);
    int v;
    v = (a >= b) ? int'(a) : int'(b);
    if (v > lim) v = lim;
    return v[9:0];
  endfunction

  // Monitor: every word the FIFO actually takes must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && we && !full) begin
      if (sb.size() == 0) begin
        chk("extra_word", {16'h0, data}, 32'hFFFF_FFFF);
      end else begin
        chk("word", {16'h0, data}, {16'h0, sb.pop_front()});
      end
    end
  end

  // Wait for ready, present one request for exactly one accepting edge, record expected words
  task automatic accept(input logic op, input logic [2:0] c,
                        input logic [9:0] x0, input logic [8:0] y0,
                        input logic [9:0] x1, input logic [8:0] y1);
    int n;
    logic [9:0] xl, xh, yl, yh;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'h0, req_ready}, 32'h1);
    xl = ref_lo(x0, x1, 639);
    xh = ref_hi(x0, x1, 639);
    yl = ref_lo({1'b0, y0}, {1'b0, y1}, 479);
    yh = ref_hi({1'b0, y0}, {1'b0, y1}, 479);
    if (op) begin
      sb.push_back({4'h2, 9'h0, c});
    end else begin
      sb.push_back({4'h1, 9'h0, c});
      sb.push_back({6'h0, xl});
      sb.push_back({7'h0, yl[8:0]});
      sb.push_back({6'h0, xh});
      sb.push_back({7'h0, yh[8:0]});
    end
    req_op = op; req_color = c;
    req_x0 = x0; req_x1 = x1; req_y0 = y0; req_y1 = y1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scramble inputs: the latched command must not follow them
    req_op    = $urandom_range(0, 1);
    req_color = 3'($urandom);
    req_x0    = 10'($urandom);
    req_x1    = 10'($urandom);
    req_y0    = 9'($urandom);
    req_y1    = 9'($urandom);
  endtask

  task automatic drain(input bit rand_full);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      if (rand_full) full = ($urandom_range(0, 3) == 0);
      n++;
    end
    full = 1'b0;
    chk("drain_in_budget", {31'h0, (n < 500)}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_color = '0;
    req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0; full = 1'b0;

    // 1: reset held 3 cycles, outputs quiet throughout
    repeat (3) begin
      @(negedge clk);
      chk("rst_we", {31'h0, we}, 32'h0);
      chk("rst_data", {16'h0, data}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_ready", {31'h0, req_ready}, 32'h0);
    end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    // 2: basic RECT, five consecutive words then ready again
    accept(1'b0, 3'b101, 10'd10, 9'd20, 10'd100, 9'd50);
    repeat (5) begin
      @(negedge clk);
      chk("rect_we_run", {31'h0, we}, 32'h1);
      chk("rect_busy_run", {31'h0, busy}, 32'h1);
    end
    @(negedge clk);
    chk("rect_ready_after", {31'h0, req_ready}, 32'h1);
    chk("rect_we_after", {31'h0, we}, 32'h0);

    // 3: swapped and off-screen corners clamp
    accept(1'b0, 3'b111, 10'd700, 9'd479, 10'd5, 9'd600);
    drain(1'b0);

    // 4: stall on the Y0 word for 4 cycles
    accept(1'b0, 3'b011, 10'd30, 9'd40, 10'd20, 9'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    full = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_we", {31'h0, we}, 32'h1);
      chk("stall_data", {16'h0, data}, 32'h0000_000A);
      chk("stall_busy", {31'h0, busy}, 32'h1);
      @(posedge clk); #1;
    end
    full = 1'b0;
    drain(1'b0);

    // 5: CLEAR is a single header word, busy for one cycle
    accept(1'b1, 3'b010, 10'd123, 9'd45, 10'd678, 9'd301);
    @(negedge clk);
    chk("clr_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("clr_busy_end", {31'h0, busy}, 32'h0);
    chk("clr_ready", {31'h0, req_ready}, 32'h1);

    // Zero-size rectangle issues normally
    accept(1'b0, 3'b001, 10'd639, 9'd479, 10'd639, 9'd479);
    drain(1'b0);

    // 6: reset during X1 drops the rest; next RECT starts at HDR
    accept(1'b0, 3'b110, 10'd1, 9'd2, 10'd3, 9'd4);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_we", {31'h0, we}, 32'h0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_we_next", {31'h0, we}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    accept(1'b0, 3'b100, 10'd50, 9'd60, 10'd40, 9'd30);
    drain(1'b0);

    // Mixed requests under random backpressure
    for (int i = 0; i < 8; i++) begin
      accept(1'($urandom_range(0, 1)), 3'($urandom), 10'($urandom), 9'($urandom),
             10'($urandom), 9'($urandom));
      drain(1'b1);
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
